dmi_master: RTL and testbench

DMI_MASTER -- requirements
Module: dmi_master

---
 rtl/dmi_pkg.sv | 29 ++
 rtl/dmi_master_if.sv | 53 +++++
 rtl/dmi_timeout_ctr.sv | 31 +++
 rtl/dmi_master.sv | 106 ++++++++++
 tb/tb_dmi_master.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dmi_pkg.sv
// Shared DMI master definitions: op and status encodings,
// FSM states and default widths.
package dmi_pkg;

    localparam int ADDR_W_DEF  = 7;
    localparam int DATA_W_DEF  = 32;
    localparam int TIMEOUT_DEF = 255;

    typedef enum logic [1:0] {
        OP_NOP   = 2'd0,
        OP_READ  = 2'd1,
        OP_WRITE = 2'd2,
        OP_RSVD  = 2'd3
    } dmi_op_e;

    typedef enum logic [1:0] {
        ST_OK      = 2'd0,
        ST_TIMEOUT = 2'd1,
        ST_ILLEGAL = 2'd2
    } host_status_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_e;

endpackage

// File: rtl/dmi_master_if.sv
// Host command/result and DMI request/response bundle.
// master is the DMI master's view, slave is the environment's.
interface dmi_master_if
    import dmi_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) ();

    logic              host_cmd_valid;
    logic              host_cmd_ready;
    logic [1:0]        host_cmd_op;
    logic [ADDR_W-1:0] host_cmd_addr;
    logic [DATA_W-1:0] host_cmd_data;

    logic              host_rsp_valid;
    logic              host_rsp_ready;
    logic [DATA_W-1:0] host_rsp_data;
    logic [1:0]        host_rsp_status;

    logic              dmi_req_valid;
    logic              dmi_req_ready;
    logic [1:0]        dmi_req_bits_op;
    logic [ADDR_W-1:0] dmi_req_bits_addr;
    logic [DATA_W-1:0] dmi_req_bits_data;

    logic              dmi_resp_valid;
    logic              dmi_resp_ready;
    logic [DATA_W-1:0] dmi_resp_bits_data;

    modport master (
        input  host_cmd_valid, host_cmd_op, host_cmd_addr,
        input  host_cmd_data, host_rsp_ready,
        input  dmi_req_ready, dmi_resp_valid, dmi_resp_bits_data,
        output host_cmd_ready, host_rsp_valid,
        output host_rsp_data, host_rsp_status,
        output dmi_req_valid, dmi_req_bits_op,
        output dmi_req_bits_addr, dmi_req_bits_data,
        output dmi_resp_ready
    );

    modport slave (
        output host_cmd_valid, host_cmd_op, host_cmd_addr,
        output host_cmd_data, host_rsp_ready,
        output dmi_req_ready, dmi_resp_valid, dmi_resp_bits_data,
        input  host_cmd_ready, host_rsp_valid,
        input  host_rsp_data, host_rsp_status,
        input  dmi_req_valid, dmi_req_bits_op,
        input  dmi_req_bits_addr, dmi_req_bits_data,
        input  dmi_resp_ready
    );

endinterface

// File: rtl/dmi_timeout_ctr.sv
// Saturating response-wait counter; expired once the
// count reaches TIMEOUT.
module dmi_timeout_ctr
    import dmi_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;

    assign expired = (cnt == CW'(TIMEOUT));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && !expired) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/dmi_master.sv
// Host-to-DMI bridge with one outstanding transaction and
// a bounded wait for the core's response.
module dmi_master
    import dmi_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input logic         clock,
    input logic         reset_n,
    dmi_master_if.master bus
);

    state_e            state;
    logic [1:0]        op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] rsp_data_q;
    host_status_e      rsp_status_q;
    logic              expired;
    logic              ctr_clear;
    logic              ctr_en;

    // Counting starts at the acceptance edge, so the count
    // equals the number of WAIT cycles spent so far.
    assign ctr_clear = (state == S_IDLE);
    assign ctr_en    = ((state == S_REQ) && bus.dmi_req_ready)
                    || ((state == S_WAIT) && !bus.dmi_resp_valid);

    dmi_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_ctr (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (ctr_clear),
        .enable  (ctr_en),
        .expired (expired)
    );

    assign bus.host_cmd_ready    = (state == S_IDLE);
    assign bus.dmi_req_valid     = (state == S_REQ);
    assign bus.dmi_resp_ready    = (state == S_WAIT);
    assign bus.host_rsp_valid    = (state == S_DONE);
    assign bus.host_rsp_data     = rsp_data_q;
    assign bus.host_rsp_status   = rsp_status_q;
    assign bus.dmi_req_bits_op   = op_q;
    assign bus.dmi_req_bits_addr = addr_q;
    assign bus.dmi_req_bits_data = data_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            op_q         <= '0;
            addr_q       <= '0;
            data_q       <= '0;
            rsp_data_q   <= '0;
            rsp_status_q <= ST_OK;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (bus.host_cmd_valid) begin
                        op_q   <= bus.host_cmd_op;
                        addr_q <= bus.host_cmd_addr;
                        data_q <= bus.host_cmd_data;
                        unique case (bus.host_cmd_op)
                            OP_READ, OP_WRITE: begin
                                state <= S_REQ;
                            end
                            OP_NOP: begin
                                state        <= S_DONE;
                                rsp_data_q   <= '0;
                                rsp_status_q <= ST_OK;
                            end
                            default: begin
                                state        <= S_DONE;
                                rsp_data_q   <= '0;
                                rsp_status_q <= ST_ILLEGAL;
                            end
                        endcase
                    end
                end
                S_REQ: begin
                    if (bus.dmi_req_ready) state <= S_WAIT;
                end
                S_WAIT: begin
                    // A response in the expiry cycle still wins.
                    if (bus.dmi_resp_valid) begin
                        state        <= S_DONE;
                        rsp_status_q <= ST_OK;
                        rsp_data_q   <= (op_q == OP_READ)
                                      ? bus.dmi_resp_bits_data
                                      : '0;
                    end else if (expired) begin
                        state        <= S_DONE;
                        rsp_status_q <= ST_TIMEOUT;
                        rsp_data_q   <= '0;
                    end
                end
                S_DONE: begin
                    if (bus.host_rsp_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmi_master.sv
// Randomized bench for dmi_master: two instances (short and
// default timeout) share stimulus, one selected at a time.
module tb_dmi_master;
    import dmi_pkg::*;

    localparam int AW    = 7;
    localparam int DW    = 32;
    localparam int TO_A  = 4;
    localparam int TO_B  = 255;
    localparam int BOUND = 600;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    logic          sel;
    logic          cmd_valid;
    logic [1:0]    cmd_op;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_data;
    logic          rsp_ready;
    logic          req_ready;
    logic          resp_valid;
    logic [DW-1:0] resp_data;

    dmi_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus_a ();
    dmi_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus_b ();

    assign bus_a.host_cmd_valid     = cmd_valid & ~sel;
    assign bus_b.host_cmd_valid     = cmd_valid & sel;
    assign bus_a.host_cmd_op        = cmd_op;
    assign bus_b.host_cmd_op        = cmd_op;
    assign bus_a.host_cmd_addr      = cmd_addr;
    assign bus_b.host_cmd_addr      = cmd_addr;
    assign bus_a.host_cmd_data      = cmd_data;
    assign bus_b.host_cmd_data      = cmd_data;
    assign bus_a.host_rsp_ready     = rsp_ready;
    assign bus_b.host_rsp_ready     = rsp_ready;
    assign bus_a.dmi_req_ready      = req_ready;
    assign bus_b.dmi_req_ready      = req_ready;
    assign bus_a.dmi_resp_valid     = resp_valid;
    assign bus_b.dmi_resp_valid     = resp_valid;
    assign bus_a.dmi_resp_bits_data = resp_data;
    assign bus_b.dmi_resp_bits_data = resp_data;

    dmi_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO_A)) dut_a (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus_a)
    );

    dmi_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO_B)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus_b)
    );

    wire          o_cmd_ready  = sel ? bus_b.host_cmd_ready : bus_a.host_cmd_ready;
    wire          o_rsp_valid  = sel ? bus_b.host_rsp_valid : bus_a.host_rsp_valid;
    wire [DW-1:0] o_rsp_data   = sel ? bus_b.host_rsp_data : bus_a.host_rsp_data;
    wire [1:0]    o_rsp_status = sel ? bus_b.host_rsp_status : bus_a.host_rsp_status;
    wire          o_req_valid  = sel ? bus_b.dmi_req_valid : bus_a.dmi_req_valid;
    wire [1:0]    o_req_op     = sel ? bus_b.dmi_req_bits_op : bus_a.dmi_req_bits_op;
    wire [AW-1:0] o_req_addr   = sel ? bus_b.dmi_req_bits_addr : bus_a.dmi_req_bits_addr;
    wire [DW-1:0] o_req_data   = sel ? bus_b.dmi_req_bits_data : bus_a.dmi_req_bits_data;
    wire          o_resp_ready = sel ? bus_b.dmi_resp_ready : bus_a.dmi_resp_ready;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)",
                      tag, got, exp, $time);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic quiet();
        cmd_valid  = 1'b0;
        cmd_op     = '0;
        cmd_addr   = '0;
        cmd_data   = '0;
        rsp_ready  = 1'b0;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_data  = '0;
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_rsp_valid"}, 64'(o_rsp_valid), 64'd0);
        check({tag, "_req_valid"}, 64'(o_req_valid), 64'd0);
        check({tag, "_resp_ready"}, 64'(o_resp_ready), 64'd0);
        check({tag, "_rsp_data"}, 64'(o_rsp_data), 64'd0);
        check({tag, "_rsp_status"}, 64'(o_rsp_status), 64'd0);
        check({tag, "_req_payload"},
              64'({o_req_op, o_req_addr, o_req_data}), 64'd0);
    endtask

    // delay: cycle after acceptance carrying the response, 0 = never.
    task automatic run_txn(input logic [1:0] op, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, input int stall,
                           input int delay, input logic [DW-1:0] rdata,
                           input int hold);
        int            to_cur;
        int            cyc;
        logic [1:0]    exp_st;
        logic [DW-1:0] exp_d;
        to_cur = sel ? TO_B : TO_A;
        if (op == 2'd0) begin
            exp_st = 2'd0; exp_d = '0;
        end else if (op == 2'd3) begin
            exp_st = 2'd2; exp_d = '0;
        end else if (delay >= 1 && delay <= to_cur) begin
            exp_st = 2'd0; exp_d = (op == 2'd1) ? rdata : '0;
        end else begin
            exp_st = 2'd1; exp_d = '0;
        end

        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_data  = wdata;
        check("cmd_ready_idle", 64'(o_cmd_ready), 64'd1);
        tick();
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom);
        cmd_addr  = AW'($urandom);
        cmd_data  = $urandom;

        if (op == 2'd1 || op == 2'd2) begin
            for (int i = 0; i <= stall; i++) begin
                check("req_valid", 64'(o_req_valid), 64'd1);
                check("req_payload", 64'({o_req_op, o_req_addr, o_req_data}),
                      64'({op, addr, wdata}));
                check("cmd_ready_busy", 64'(o_cmd_ready), 64'd0);
                check("resp_ready_req", 64'(o_resp_ready), 64'd0);
                resp_valid = 1'($urandom);
                resp_data  = $urandom;
                req_ready  = (i == stall);
                tick();
            end
            req_ready  = 1'b0;
            resp_valid = 1'b0;
            check("req_dropped", 64'(o_req_valid), 64'd0);
            check("resp_ready_wait", 64'(o_resp_ready), 64'd1);
            cyc = 1;
            while (!o_rsp_valid && cyc < BOUND) begin
                if (cyc == delay) begin
                    resp_valid = 1'b1;
                    resp_data  = rdata;
                end
                tick();
                resp_valid = 1'b0;
                cyc++;
            end
            check("rsp_latency", 64'(cyc),
                  64'((delay >= 1 && delay <= to_cur) ? delay + 1 : to_cur + 1));
        end else begin
            check("no_dmi_req", 64'(o_req_valid), 64'd0);
        end

        check("rsp_valid", 64'(o_rsp_valid), 64'd1);
        for (int h = 0; h < hold; h++) begin
            check("hold_valid", 64'(o_rsp_valid), 64'd1);
            check("hold_status", 64'(o_rsp_status), 64'(exp_st));
            check("hold_data", 64'(o_rsp_data), 64'(exp_d));
            check("resp_ready_done", 64'(o_resp_ready), 64'd0);
            resp_valid = 1'b1;
            resp_data  = $urandom;
            tick();
        end
        resp_valid = 1'b0;
        check("rsp_status", 64'(o_rsp_status), 64'(exp_st));
        check("rsp_data", 64'(o_rsp_data), 64'(exp_d));
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("rsp_released", 64'(o_rsp_valid), 64'd0);
        check("cmd_ready_back", 64'(o_cmd_ready), 64'd1);
    endtask

    initial begin
        int d;
        quiet();
        sel     = 1'b0;
        reset_n = 1'b0;
        repeat (2) tick();
        check_reset_outs("rst_a");
        sel = 1'b1;
        check_reset_outs("rst_b");
        reset_n = 1'b1;
        tick();
        check("cmd_ready_after_rst", 64'(o_cmd_ready), 64'd1);

        run_txn(2'd2, 7'h10, 32'hDEADBEEF, 0, 3, 32'h0, 1);
        run_txn(2'd1, 7'h11, 32'h0, 0, 5, 32'h00C0FFEE, 0);

        sel = 1'b0;
        run_txn(2'd1, 7'h22, 32'h0, 0, 0, 32'h0, 2);
        run_txn(2'd1, 7'h23, 32'h0, 0, TO_A, 32'h12345678, 0);
        run_txn(2'd1, 7'h24, 32'h0, 0, TO_A + 1, 32'h9ABCDEF0, 1);
        run_txn(2'd2, 7'h3C, 32'hA5A5_5A5A, 10, 2, 32'h0, 0);
        run_txn(2'd0, 7'h01, 32'h1111_1111, 0, 0, 32'h0, 1);
        run_txn(2'd3, 7'h02, 32'h2222_2222, 0, 0, 32'h0, 0);

        // Reset pulsed while waiting for a response.
        cmd_valid = 1'b1;
        cmd_op    = 2'd1;
        cmd_addr  = 7'h55;
        cmd_data  = 32'hCAFE0000;
        tick();
        cmd_valid = 1'b0;
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        tick();
        check("wait_before_rst", 64'(o_resp_ready), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        check_reset_outs("rst_mid");
        tick();
        #2 reset_n = 1'b1;
        resp_valid = 1'b1;
        resp_data  = 32'hBAD0BAD0;
        repeat (2) tick();
        check("stale_resp_ignored", 64'(o_rsp_valid), 64'd0);
        check("stale_resp_ready", 64'(o_resp_ready), 64'd0);
        resp_valid = 1'b0;
        run_txn(2'd1, 7'h56, 32'h0, 1, 2, 32'h0BADF00D, 0);

        for (int t = 0; t < 40; t++) begin
            logic [1:0] op;
            sel = 1'($urandom);
            op  = ($urandom_range(0, 9) < 8) ? 2'($urandom_range(1, 2))
                                             : 2'($urandom);
            if (sel) d = ($urandom_range(0, 15) == 0) ? 0
                                                      : $urandom_range(1, 8);
            else     d = $urandom_range(0, TO_A + 2);
            run_txn(op, AW'($urandom), $urandom, $urandom_range(0, 3), d,
                    $urandom, $urandom_range(0, 2));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
